// File: rtl/mem_ctrl_pkg.sv
// Shared widths, encodings and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;
    localparam logic [InstLen-1:0] ZERO_WORD = '0;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    // Index of the final byte; 11 behaves as a word.
    function automatic logic [1:0] last_idx(input logic [1:0] len);
        logic [1:0] r;
        case (len)
            LEN_B:   r = 2'd0;
            LEN_H:   r = 2'd1;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates i_cache refill and MEM stage onto one 8-bit RAM port,
// sequencing little-endian 1/2/4-byte reads and writes.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_req,
    input  logic [AddrLen-1:0] if_addr,
    output logic               if_done,
    output logic [InstLen-1:0] if_data,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [1:0]         mem_len,
    input  logic [AddrLen-1:0] mem_addr,
    input  logic [InstLen-1:0] mem_wdata,
    output logic               mem_done,
    output logic [InstLen-1:0] mem_rdata,
    output logic [AddrLen-1:0] ram_a,
    output logic [7:0]         ram_dout,
    output logic               ram_wr,
    input  logic [7:0]         ram_din
);

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [1:0]         iss_q, iss_d;
    logic [1:0]         cap_q, cap_d;
    logic               cap_en_q, cap_en_d;
    logic [1:0]         last_q, last_d;
    logic [AddrLen-1:0] base_q, base_d;
    logic [InstLen-1:0] data_q, data_d;
    logic [InstLen-1:0] wdata_q, wdata_d;
    logic [AddrLen-1:0] ram_a_q, ram_a_d;
    logic [7:0]         ram_dout_q, ram_dout_d;
    logic               ram_wr_q, ram_wr_d;
    logic [1:0]         iss_nxt;
    logic [AddrLen-1:0] grant_addr;

    assign iss_nxt    = iss_q + 2'd1;
    assign grant_addr = mem_req ? mem_addr : if_addr;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        iss_d      = iss_q;
        cap_d      = cap_q;
        cap_en_d   = cap_en_q;
        last_d     = last_q;
        base_d     = base_q;
        data_d     = data_q;
        wdata_d    = wdata_q;
        ram_a_d    = ram_a_q;
        ram_dout_d = 8'h00;
        ram_wr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req || if_req) begin
                    owner_d  = mem_req ? OWN_MEM : OWN_IF;
                    base_d   = grant_addr;
                    ram_a_d  = grant_addr;
                    last_d   = mem_req ? last_idx(mem_len) : 2'd3;
                    wdata_d  = mem_req ? mem_wdata : ZERO_WORD;
                    data_d   = ZERO_WORD;
                    iss_d    = 2'd0;
                    cap_d    = 2'd0;
                    cap_en_d = 1'b0;
                    if (mem_req && mem_we) begin
                        state_d    = WR;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                // Capture lags issue by one cycle to match RAM read latency.
                cap_en_d = 1'b1;
                if (iss_q != last_q) begin
                    iss_d   = iss_nxt;
                    ram_a_d = base_q + {30'b0, iss_nxt};
                end
                if (cap_en_q) begin
                    data_d[{cap_q, 3'b000} +: 8] = ram_din;
                    cap_d = cap_q + 2'd1;
                    if (cap_q == last_q) begin
                        state_d = DONE;
                    end
                end
            end
            WR: begin
                if (iss_q == last_q) begin
                    state_d = DONE;
                end else begin
                    iss_d      = iss_nxt;
                    ram_a_d    = base_q + {30'b0, iss_nxt};
                    ram_wr_d   = 1'b1;
                    ram_dout_d = wdata_q[{iss_nxt, 3'b000} +: 8];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            iss_q      <= 2'd0;
            cap_q      <= 2'd0;
            cap_en_q   <= 1'b0;
            last_q     <= 2'd0;
            base_q     <= '0;
            data_q     <= ZERO_WORD;
            wdata_q    <= ZERO_WORD;
            ram_a_q    <= '0;
            ram_dout_q <= 8'h00;
            ram_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            iss_q      <= iss_d;
            cap_q      <= cap_d;
            cap_en_q   <= cap_en_d;
            last_q     <= last_d;
            base_q     <= base_d;
            data_q     <= data_d;
            wdata_q    <= wdata_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
        end
    end

    assign if_done   = (state_q == DONE) && (owner_q == OWN_IF);
    assign mem_done  = (state_q == DONE) && (owner_q == OWN_MEM);
    assign if_data   = data_q;
    assign mem_rdata = data_q;
    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q;

endmodule
